mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 122 ++++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction between EXE and WB, waits for the
// data SRAM response of loads, aligns/extends load data and feeds the bypass network.
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   output logic        ms_allowin,
   input  logic        es_to_ms_valid,
   input  logic [73:0] es_to_ms_bus,
   input  logic        ws_allowin,
   output logic        ms_to_ws_valid,
   output logic [69:0] ms_to_ws_bus,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        ms_fwd_valid,
   output logic [4:0]  ms_fwd_dest,
   output logic        ms_fwd_ready,
   output logic [31:0] ms_fwd_data
);

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_B    = 3'd1,
      LD_BU   = 3'd2,
      LD_H    = 3'd3,
      LD_HU   = 3'd4,
      LD_W    = 3'd5
   } load_t;

   logic [73:0] es_bus_r;
   logic        ms_valid;
   logic        buf_valid;
   logic [31:0] data_buf;

   logic [2:0]  load_type;
   logic        gr_we;
   logic        mem_req;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;

   logic        ms_ready_go;
   logic        data_ok_now;
   logic [31:0] load_word;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] final_result;

   assign {load_type, gr_we, mem_req, dest, alu_result, pc} = es_bus_r;

   // A response only belongs to a live load that has not already been buffered.
   assign data_ok_now    = data_sram_data_ok && ms_valid && mem_req && !buf_valid;
   assign ms_ready_go    = !mem_req || data_ok_now || buf_valid;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end
   end

   // NOTE: payload registers carry no reset; they are ignored while ms_valid=0.
   always_ff @(posedge clk) begin
      if (es_to_ms_valid && ms_allowin) begin
         es_bus_r <= es_to_ms_bus;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
      end else if (ms_to_ws_valid && ws_allowin) begin
         buf_valid <= 1'b0;
      end else if (data_ok_now && !ws_allowin) begin
         buf_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (data_ok_now && !ws_allowin) begin
         data_buf <= data_sram_rdata;
      end
   end

   assign load_word = buf_valid ? data_buf : data_sram_rdata;
   assign load_half = alu_result[1] ? load_word[31:16] : load_word[15:0];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      load_byte = load_word[7:0];
      case (alu_result[1:0])
         2'd1:    load_byte = load_word[15:8];
         2'd2:    load_byte = load_word[23:16];
         2'd3:    load_byte = load_word[31:24];
         default: load_byte = load_word[7:0];
      endcase
   end

   always_comb begin
      final_result = alu_result;
      case (load_type)
         LD_B:    final_result = {{24{load_byte[7]}}, load_byte};
         LD_BU:   final_result = {24'd0, load_byte};
         LD_H:    final_result = {{16{load_half[15]}}, load_half};
         LD_HU:   final_result = {16'd0, load_half};
         LD_W:    final_result = load_word;
         default: final_result = alu_result;
      endcase
   end

   assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

   assign ms_fwd_valid = ms_valid && gr_we && (dest != 5'd0);
   assign ms_fwd_dest  = dest;
   assign ms_fwd_ready = ms_ready_go;
   assign ms_fwd_data  = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: cycle-driven stimulus, expected WB
// transfers queued at latch time and compared when the stage hands off to WB.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [73:0] es_to_ms_bus;
   logic        ws_allowin;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ms_fwd_valid;
   logic [4:0]  ms_fwd_dest;
   logic        ms_fwd_ready;
   logic [31:0] ms_fwd_data;

   int total = 0;
   int bad   = 0;
   logic [69:0] sb[$];

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_fwd_valid      (ms_fwd_valid),
      .ms_fwd_dest       (ms_fwd_dest),
      .ms_fwd_ready      (ms_fwd_ready),
      .ms_fwd_data       (ms_fwd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [73:0] mk(input logic [2:0] lt, input logic we, input logic mreq,
                                      input logic [4:0] dst, input logic [31:0] alu,
                                      input logic [31:0] pc);
      return {lt, we, mreq, dst, alu, pc};
   endfunction

   // Reference load formatter.
   function automatic logic [31:0] model(input logic [2:0] lt, input logic [31:0] alu,
                                         input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*alu[1:0] +: 8];
      h = alu[1] ? w[31:16] : w[15:0];
      case (lt)
         3'd1:    return {{24{b[7]}}, b};
         3'd2:    return {24'h0, b};
         3'd3:    return {{16{h[15]}}, h};
         3'd4:    return {16'h0, h};
         3'd5:    return w;
         default: return alu;
      endcase
   endfunction

   // One clock cycle: apply inputs, check at negedge, then step past posedge.
   task automatic drive(input logic ev, input logic [73:0] b, input logic [31:0] exp_res,
                        input logic dok, input logic [31:0] rd, input logic wa,
                        input int exp_ov, input int exp_aw);
      logic [69:0] e;
      es_to_ms_valid    = ev;
      es_to_ms_bus      = b;
      data_sram_data_ok = dok;
      data_sram_rdata   = rd;
      ws_allowin        = wa;
      @(negedge clk);
      if (exp_ov >= 0) check("to_ws_valid", {69'd0, ms_to_ws_valid}, {69'd0, exp_ov[0]});
      if (exp_aw >= 0) check("allowin", {69'd0, ms_allowin}, {69'd0, exp_aw[0]});
      if (ms_to_ws_valid && ws_allowin) begin
         if (sb.size() == 0) begin
            check("unexpected_out", {69'd0, ms_to_ws_valid}, 70'd0);
         end else begin
            e = sb.pop_front();
            check("ws_bus", ms_to_ws_bus, e);
            check("fwd_data", {38'd0, ms_fwd_data}, {38'd0, e[63:32]});
            check("fwd_ready", {69'd0, ms_fwd_ready}, 70'd1);
            check("fwd_dest", {65'd0, ms_fwd_dest}, {65'd0, e[68:64]});
            check("fwd_valid", {69'd0, ms_fwd_valid}, {69'd0, e[69] && (e[68:64] != 5'd0)});
         end
      end
      if (ev && ms_allowin) sb.push_back({b[70], b[68:64], exp_res, b[31:0]});
      @(posedge clk);
      #1;
   endtask

   logic [73:0] b0, b1, b2, b3;

   initial begin
      reset = 1'b1;
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      ws_allowin = 1'b1;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_to_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
      check("rst_fwd_valid", {69'd0, ms_fwd_valid}, 70'd0);
      check("rst_allowin", {69'd0, ms_allowin}, 70'd1);
      @(posedge clk);
      #1;

      // ALU op delivered the cycle after latch.
      b0 = mk(3'd0, 1'b1, 1'b0, 5'd8, 32'h1234_5678, 32'h0000_1000);
      drive(1'b1, b0, 32'h1234_5678, 1'b0, 32'h0, 1'b1, -1, 1);
      drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 1, 1);
      drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 1);

      // Back-to-back loads with data_ok the cycle after latch: LB, LBU, LH.
      b0 = mk(3'd1, 1'b1, 1'b1, 5'd3, 32'h0000_2003, 32'h0000_1100);
      b1 = mk(3'd2, 1'b1, 1'b1, 5'd4, 32'h0000_2003, 32'h0000_1104);
      b2 = mk(3'd3, 1'b1, 1'b1, 5'd5, 32'h0000_2000, 32'h0000_1108);
      drive(1'b1, b0, 32'hFFFF_FF80, 1'b0, 32'h0, 1'b1, 0, 1);
      drive(1'b1, b1, 32'h0000_0080, 1'b1, 32'h80FF_0011, 1'b1, 1, 1);
      drive(1'b1, b2, model(3'd3, 32'h0000_2000, 32'h1234_F00D), 1'b1, 32'h80FF_0011, 1'b1, 1, 1);
      drive(1'b0, '0, 32'h0, 1'b1, 32'h1234_F00D, 1'b1, 1, 1);
      drive(1'b0, '0, 32'h0, 1'b1, 32'hAAAA_AAAA, 1'b1, 0, 1);

      // LH upper lane, response delayed 3 cycles.
      b0 = mk(3'd3, 1'b1, 1'b1, 5'd9, 32'h0000_3002, 32'h0000_1200);
      drive(1'b1, b0, 32'hFFFF_8001, 1'b0, 32'h0, 1'b1, -1, 1);
      repeat (3) drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0);
      drive(1'b0, '0, 32'h0, 1'b1, 32'h8001_7FFF, 1'b1, 1, 1);

      // LHU and LB lane 1 through the reference model.
      b0 = mk(3'd4, 1'b1, 1'b1, 5'd10, 32'h0000_3003, 32'h0000_1300);
      b1 = mk(3'd1, 1'b1, 1'b1, 5'd11, 32'h0000_3001, 32'h0000_1304);
      drive(1'b1, b0, model(3'd4, 32'h0000_3003, 32'hC3A5_0102), 1'b0, 32'h0, 1'b1, -1, 1);
      drive(1'b1, b1, model(3'd1, 32'h0000_3001, 32'h0000_9F00), 1'b1, 32'hC3A5_0102, 1'b1, 1, 1);
      drive(1'b0, '0, 32'h0, 1'b1, 32'h0000_9F00, 1'b1, 1, 1);

      // LW buffered while WB stalls; stray data_ok and rdata changes ignored.
      b0 = mk(3'd5, 1'b1, 1'b1, 5'd12, 32'h0000_4000, 32'h0000_1400);
      b1 = mk(3'd5, 1'b1, 1'b1, 5'd13, 32'h0000_4004, 32'h0000_1404);
      drive(1'b1, b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, -1, 1);
      drive(1'b0, '0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1, 0);
      drive(1'b0, '0, 32'h0, 1'b1, 32'h1111_2222, 1'b0, 1, 0);
      check("buf_hold", {38'd0, ms_fwd_data}, {38'd0, 32'hDEAD_BEEF});
      // Exit and entry in the same cycle: the new LW must wait for its own data.
      drive(1'b1, b1, 32'h0BAD_F00D, 1'b0, 32'h3333_4444, 1'b1, 1, 1);
      drive(1'b0, '0, 32'h0, 1'b0, 32'h5555_6666, 1'b1, 0, 0);
      drive(1'b0, '0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1, 1, 1);

      // Stream of four non-memory ops, one per cycle, including gr_we=0, dest=0, type 6.
      b0 = mk(3'd0, 1'b1, 1'b0, 5'd1,  32'hA000_0001, 32'h0000_1500);
      b1 = mk(3'd0, 1'b0, 1'b0, 5'd2,  32'hA000_0002, 32'h0000_1504);
      b2 = mk(3'd0, 1'b1, 1'b0, 5'd0,  32'hA000_0003, 32'h0000_1508);
      b3 = mk(3'd6, 1'b1, 1'b0, 5'd31, 32'hA000_0007, 32'h0000_150C);
      drive(1'b1, b0, 32'hA000_0001, 1'b0, 32'h0, 1'b1, -1, 1);
      drive(1'b1, b1, 32'hA000_0002, 1'b0, 32'h0, 1'b1, 1, 1);
      drive(1'b1, b2, 32'hA000_0003, 1'b0, 32'h0, 1'b1, 1, 1);
      drive(1'b1, b3, 32'hA000_0007, 1'b0, 32'h0, 1'b1, 1, 1);
      drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 1, 1);
      drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 1);

      // Reset while an LW waits; late data_ok must be discarded.
      b0 = mk(3'd5, 1'b1, 1'b1, 5'd14, 32'h0000_5000, 32'h0000_1600);
      drive(1'b1, b0, 32'h0, 1'b0, 32'h0, 1'b1, -1, 1);
      reset = 1'b1;
      drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0);
      drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 0, -1);
      reset = 1'b0;
      sb.delete();
      drive(1'b0, '0, 32'h0, 1'b1, 32'h7777_7777, 1'b1, 0, 1);
      check("rst_fwd_valid2", {69'd0, ms_fwd_valid}, 70'd0);
      drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 1);

      // Normal load after reset recovery.
      b0 = mk(3'd5, 1'b1, 1'b1, 5'd15, 32'h0000_6000, 32'h0000_1700);
      drive(1'b1, b0, 32'hCAFE_0001, 1'b0, 32'h0, 1'b1, -1, 1);
      drive(1'b0, '0, 32'h0, 1'b1, 32'hCAFE_0001, 1'b1, 1, 1);
      drive(1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 1);

      check("sb_drained", {38'd0, 32'(sb.size())}, 70'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
